// File: rtl/id_regfile_sb.sv
// Decode-stage register file with HI/LO, optional write-through bypass
// and a pending-write scoreboard that raises a decode stall.
module id_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] ReadAddress1,
  input  logic [ADDR_W-1:0] ReadAddress2,
  input  logic              Read1Used,
  input  logic              Read2Used,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteAddress,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [1:0]        HiLoWrite,
  input  logic [DATA_W-1:0] HiWriteData,
  input  logic [DATA_W-1:0] LoWriteData,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueAddress,
  input  logic              Flush,
  output logic              Stall,
  output logic [ADDR_W:0]   BusyCount
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit BYP   = (BYPASS != 0);
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wr_ok;
  logic              iss_ok;
  logic              clr1;
  logic              clr2;

  assign wr_ok  = RegWrite &
                  ~(ZR && (WriteAddress == '0));
  assign iss_ok = IssueValid &
                  ~(ZR && (IssueAddress == '0));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (wr_ok)
        regs[WriteAddress] <= WriteData;
      if (HiLoWrite[1])
        hi_q <= HiWriteData;
      if (HiLoWrite[0])
        lo_q <= LoWriteData;
    end
  end

  always_comb begin
    ReadData1 = regs[ReadAddress1];
    if (ZR && (ReadAddress1 == '0))
      ReadData1 = '0;
    else if (BYP && wr_ok &&
             (WriteAddress == ReadAddress1))
      ReadData1 = WriteData;
  end

  always_comb begin
    ReadData2 = regs[ReadAddress2];
    if (ZR && (ReadAddress2 == '0))
      ReadData2 = '0;
    else if (BYP && wr_ok &&
             (WriteAddress == ReadAddress2))
      ReadData2 = WriteData;
  end

  assign Hi = (BYP && HiLoWrite[1]) ? HiWriteData : hi_q;
  assign Lo = (BYP && HiLoWrite[0]) ? LoWriteData : lo_q;

  // Issue is applied after the writeback clear so a new producer wins.
  always_comb begin
    busy_nxt = busy;
    if (Flush) begin
      busy_nxt = '0;
    end else begin
      if (RegWrite)
        busy_nxt[WriteAddress] = 1'b0;
      if (iss_ok)
        busy_nxt[IssueAddress] = 1'b1;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      busy      <= '0;
      BusyCount <= '0;
    end else begin
      busy      <= busy_nxt;
      BusyCount <= cnt_nxt;
    end
  end

  assign clr1 = BYP & RegWrite &
                (WriteAddress == ReadAddress1);
  assign clr2 = BYP & RegWrite &
                (WriteAddress == ReadAddress2);

  assign Stall = (Read1Used & busy[ReadAddress1] & ~clr1) |
                 (Read2Used & busy[ReadAddress2] & ~clr2);

endmodule

// File: tb/tb_id_regfile_sb.sv
// Directed bench for id_regfile_sb: a bypassing instance and a
// non-bypassing instance driven from the same stimulus.
module tb_id_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] ra1, ra2;
  logic          r1u, r2u;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [1:0]    hlw;
  logic [DW-1:0] hwd, lwd;
  logic          iv;
  logic [AW-1:0] ia;
  logic          flush;

  logic [DW-1:0] rd1, rd2, hi, lo;
  logic          stall;
  logic [AW:0]   bcnt;
  logic [DW-1:0] nb_rd1, nb_rd2, nb_hi, nb_lo;
  logic          nb_stall;
  logic [AW:0]   nb_bcnt;

  int checks = 0;
  int errors = 0;

  id_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1), .ZERO_REG(1)) u_dut (
    .Clk(clk), .Reset(rst_n),
    .ReadAddress1(ra1), .ReadAddress2(ra2),
    .Read1Used(r1u), .Read2Used(r2u),
    .ReadData1(rd1), .ReadData2(rd2),
    .RegWrite(we), .WriteAddress(wa), .WriteData(wd),
    .HiLoWrite(hlw), .HiWriteData(hwd), .LoWriteData(lwd),
    .Hi(hi), .Lo(lo),
    .IssueValid(iv), .IssueAddress(ia), .Flush(flush),
    .Stall(stall), .BusyCount(bcnt)
  );

  id_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0), .ZERO_REG(1)) u_nb (
    .Clk(clk), .Reset(rst_n),
    .ReadAddress1(ra1), .ReadAddress2(ra2),
    .Read1Used(r1u), .Read2Used(r2u),
    .ReadData1(nb_rd1), .ReadData2(nb_rd2),
    .RegWrite(we), .WriteAddress(wa), .WriteData(wd),
    .HiLoWrite(hlw), .HiWriteData(hwd), .LoWriteData(lwd),
    .Hi(nb_hi), .Lo(nb_lo),
    .IssueValid(iv), .IssueAddress(ia), .Flush(flush),
    .Stall(nb_stall), .BusyCount(nb_bcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; iv = 0; flush = 0; hlw = 2'b00;
  endtask

  initial begin
    rst_n = 0;
    ra1 = '0; ra2 = '0; r1u = 0; r2u = 0;
    wa = '0; wd = '0; hwd = '0; lwd = '0; ia = '0;
    idle();
    #3;
    check("rst_bcnt", bcnt, 0);
    check("rst_stall", stall, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    #4 rst_n = 1;
    step();

    // write 7 <- 22, bypass vs no bypass
    we = 1; wa = 7; wd = 22; ra1 = 7;
    #1;
    check("byp_rd1", rd1, 22);
    check("nb_rd1_old", nb_rd1, 0);
    step();
    idle();
    #1;
    check("byp_rd1_after", rd1, 22);
    check("nb_rd1_after", nb_rd1, 22);

    // register 0
    we = 1; wa = 0; wd = 32'hFFFF; ra1 = 0;
    #1;
    check("r0_byp", rd1, 0);
    step();
    idle();
    iv = 1; ia = 0;
    step();
    idle();
    #1;
    check("r0_rd", rd1, 0);
    check("r0_bcnt", bcnt, 0);

    // load-use stall on rt = 8
    iv = 1; ia = 8;
    step();
    idle();
    ra2 = 8; r2u = 1;
    #1;
    check("stall8", stall, 1);
    check("bcnt8", bcnt, 1);
    r2u = 0;
    #1;
    check("stall8_unused", stall, 0);
    r2u = 1; we = 1; wa = 8; wd = 55;
    #1;
    check("stall8_wb_byp", stall, 0);
    check("nb_stall8_wb", nb_stall, 1);
    check("rd2_wb_byp", rd2, 55);
    step();
    idle();
    #1;
    check("bcnt8_clr", bcnt, 0);
    check("stall8_clr", stall, 0);
    check("nb_stall8_clr", nb_stall, 0);
    check("nb_bcnt8_clr", nb_bcnt, 0);
    r2u = 0;

    // issue and write same address
    iv = 1; ia = 9; we = 1; wa = 9; wd = 3;
    step();
    idle();
    ra1 = 9; r1u = 1;
    #1;
    check("bcnt9", bcnt, 1);
    check("stall9", stall, 1);
    flush = 1; iv = 1; ia = 10;
    step();
    idle();
    #1;
    check("flush_bcnt", bcnt, 0);
    check("flush_stall", stall, 0);

    // re-issue keeps count, second register adds
    iv = 1; ia = 5;
    step();
    iv = 1; ia = 5;
    step();
    idle();
    #1;
    check("reissue_bcnt", bcnt, 1);
    iv = 1; ia = 6;
    step();
    flush = 1; iv = 0;
    #1;
    check("two_bcnt", bcnt, 2);
    step();
    idle();
    #1;
    check("flush2_bcnt", bcnt, 0);

    // HI/LO
    hlw = 2'b10; hwd = 33; lwd = 44;
    #1;
    check("hi_byp", hi, 33);
    check("nb_hi_old", nb_hi, 0);
    check("lo_noload", lo, 0);
    step();
    idle();
    #1;
    check("hi_after", hi, 33);
    check("lo_after", lo, 0);
    check("nb_hi_after", nb_hi, 33);
    hlw = 2'b11; hwd = 66; lwd = 77;
    step();
    idle();
    #1;
    check("hi_both", hi, 66);
    check("lo_both", lo, 77);

    // asynchronous reset mid-run with busy bits set
    iv = 1; ia = 7;
    step();
    iv = 1; ia = 9;
    step();
    idle();
    ra1 = 7; ra2 = 9; r1u = 1; r2u = 1;
    #1;
    check("pre_rst_stall", stall, 1);
    check("pre_rst_bcnt", bcnt, 2);
    check("pre_rst_rd1", rd1, 22);
    check("pre_rst_rd2", rd2, 3);
    rst_n = 0;
    #1;
    check("arst_bcnt", bcnt, 0);
    check("arst_stall", stall, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_rd1", rd1, 0);
    check("arst_rd2", rd2, 0);
    check("arst_nb_rd1", nb_rd1, 0);
    step();
    rst_n = 1;
    step();
    check("post_rst_bcnt", bcnt, 0);
    check("post_rst_rd1", rd1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
